demux4_stream: RTL
==================

# demux4_stream

Four-way stream demultiplexer with per-channel buffering. It is the fan-out counterpart of the 4-input selector used on the datapath. One valid/ready input stream carries a 2-bit destination select. Each accepted word is steered into a 2-entry FIFO for that destination. Four independent valid/ready output channels drain the FIFOs. The block lets one producer feed up to four consumers, such as writeback ports or functional-unit issue queues, without a combinational ready path from consumers back to the producer.

## Interface
Parameters:
- WIDTH, 32, data width of every word

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input word present
- in_ready  out  1  block accepts the input word this cycle
- in_data  in  WIDTH  input word
- in_sel  in  2  destination channel, 0..3
- out_valid  out  4  bit k: channel k head entry valid
- out_ready  in  4  bit k: consumer k takes the head this cycle
- out_data0  out  WIDTH  channel 0 head word
- out_data1  out  WIDTH  channel 1 head word
- out_data2  out  WIDTH  channel 2 head word
- out_data3  out  WIDTH  channel 3 head word

## Operation
- Each channel k has a 2-entry FIFO: storage 2×WIDTH, 1-bit write pointer, 1-bit read pointer, 2-bit count (0..2).
- in_ready = (count[in_sel] != 2).
  - Depends only on in_sel and registered counts.
  - Never depends on out_ready.
  - Asserted regardless of in_valid.
- Push: in_valid && in_ready writes in_data at wptr of FIFO in_sel, then increments that wptr (wraps 1→0).
- Pop on channel k: out_valid[k] && out_ready[k] advances rptr_k (wraps 1→0).
- out_valid[k] = (count_k != 0).
- out_dataK = storage_k[rptr_k]. Value is don't-care to consumers while out_valid[k]=0, but must still follow reset rules.
- Count update per channel: +1 push only, −1 pop only, unchanged on push and pop in the same cycle or neither.
- Pops on different channels are independent; any subset of channels may pop in the same cycle.
- Only one channel can be pushed per cycle.
- Order is preserved within a channel. No ordering is defined across channels.
- in_valid=0: no state change from the input side, even if in_sel is X.
- out_ready[k]=1 while out_valid[k]=0: no effect.
- Words are never dropped or duplicated. The block has no error outputs.

## Timing
- Reset: when rst=1 at a clock edge, all counts, pointers and storage clear to 0. After reset:
  - out_valid=4'b0000, out_data0..3=0, in_ready=1 for every in_sel.
- Reset mid-operation discards every buffered word. Handshakes completing in the reset cycle are ignored.
- Latency: a word accepted at edge N drives out_valid[k]=1 and out_dataK from edge N onward. That is one cycle after the push cycle; there is no same-cycle bypass.
- Full channel (count=2) with a pop in the same cycle: the push is still refused (in_ready=0). The slot frees the next cycle.
- Count=1 with push and pop on the same channel:
  - count stays 1.
  - The head advances to the new word on the next cycle.
- Throughput: 1 word/cycle to a channel the consumer drains every cycle (count oscillates 0↔1 or stays 1). Sustained rate per channel with out_ready held high is 1 word/cycle.
- Backpressure: a full channel stalls only inputs that select that channel.

## Structure
Shared package (demux_pkg):
- NCH=4
- SEL_W=2
- FIFO_DEPTH=2
- CNT_W=2

Sub-module fifo2:
- Parameter WIDTH.
- Ports: clk, rst, push, push_data, pop, full, empty, head.
- Instantiated four times.

Top-level logic:
- Decodes in_sel into a one-hot push vector gated by in_valid && in_ready.
- Computes in_ready through a 4:1 selection of the full flags.
- Wires each pop as out_valid[k] & out_ready[k].

## Test plan
- Reset then idle:
  - Hold rst 2 cycles.
  - Expect out_valid=0000, out_data0..3=0, in_ready=1 for in_sel=0..3.
- Single steer:
  - Push 32'hA5A5_0001 with in_sel=2, out_ready=0000.
  - Next cycle expect out_valid=0100, out_data2=32'hA5A5_0001.
  - Pulse out_ready[2], then expect out_valid=0000.
- Fill and block:
  - Push 32'h11 and 32'h22 to channel 1 with out_ready=0.
  - Third push 32'h33 to channel 1: expect in_ready=0 and the word held.
  - Same cycle, in_sel=3: expect in_ready=1.
  - Pop once; next cycle 32'h33 is accepted.
  - Drain order must be 11, 22, 33.
- Full with same-cycle pop:
  - Channel 0 count=2. Assert out_ready[0]=1 and in_valid with in_sel=0.
  - Expect in_ready=0 that cycle.
  - Next cycle count=1 and in_ready=1.
- Streaming all channels:
  - Random in_sel, in_valid random at 70%, out_ready random at 50%, 10k cycles.
  - Scoreboard: per-channel order preserved, no loss or duplication, every word exits on its selected channel.
- Reset mid-operation:
  - Channels 0 and 3 hold 2 words each. Assert rst with in_valid=1.
  - Next cycle expect out_valid=0000, all out_data=0, and the input word not stored.

Source files
------------

// File: rtl/demux4_stream_pkg.sv
// Shared constants and helpers for the four-way stream demultiplexer.
// Channel count, select width and per-channel FIFO sizing live here so the top and FIFO agree.
package demux_pkg;

    localparam int NCH        = 4;
    localparam int SEL_W      = 2;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 2;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [NCH-1:0]   chvec_t;

    // Turns a channel number into a one-hot channel vector.
    function automatic chvec_t sel_onehot(input sel_t s);
        chvec_t v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux4_stream_fifo2.sv
// Two-entry FIFO that buffers one output channel of the demultiplexer.
// A push while full and a pop while empty are ignored, so callers may present raw requests.
module fifo2
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             wptr;
    logic             rptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    // A simultaneous push and pop leaves the count unchanged; the pointers still advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= ~wptr;
            end
            if (do_pop) begin
                rptr <= ~rptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux4_stream.sv
// Steers one valid/ready input stream into four buffered valid/ready output channels.
// in_ready depends only on in_sel and registered fill state, never on the consumers.
module demux4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3
);

    chvec_t           full;
    chvec_t           empty;
    chvec_t           push_vec;
    chvec_t           pop_vec;
    logic [WIDTH-1:0] head [NCH];

    assign in_ready  = ~full[in_sel];
    assign out_valid = ~empty;
    assign pop_vec   = out_valid & out_ready;

    // With in_valid low the push vector stays zero whatever in_sel holds.
    always_comb begin
        push_vec = '0;
        if (in_valid && in_ready) begin
            push_vec = sel_onehot(in_sel);
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        fifo2 #(
            .WIDTH(WIDTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (push_vec[k]),
            .push_data(in_data),
            .pop      (pop_vec[k]),
            .full     (full[k]),
            .empty    (empty[k]),
            .head     (head[k])
        );
    end

    assign out_data0 = head[0];
    assign out_data1 = head[1];
    assign out_data2 = head[2];
    assign out_data3 = head[3];

endmodule
